tile_map_gen: RTL
=================

Name: tile_map_gen

Overview:
Parametrised background tile-map generator and lookup for the tank playfield. On a start request it fills a ROWS x COLS tile map using an internal seedable 16-bit LFSR and programmable feature density. It then serves registered tile lookups for the VGA draw path. A single-tile write port lets game logic change tiles at runtime, e.g. when a tree is destroyed.

Parameters:
COLS, 80, map width in tiles (>=2)
ROWS, 60, map height in tiles (>=2)
TILE_SHIFT, 3, log2 of tile edge in pixels (8 px tiles)
TILE_W, 3, bits per tile code
FEAT_THRESH, 20, tile becomes a feature when lfsr[8:0] <= FEAT_THRESH

Ports:
Clk  in  1  system clock
Reset_h  in  1  asynchronous active-high reset
Gen  in  1  start generation; sampled in IDLE/DONE
Seed  in  16  LFSR seed, captured on accepted Gen
Busy  out  1  high while in FILL
Gen_Done  out  1  high in DONE until next accepted Gen or reset
DrawX  in  10  pixel x
DrawY  in  10  pixel y
tilenumber  out  TILE_W  registered tile code at (DrawX, DrawY)
Wr_en  in  1  single-tile write strobe
Wr_row  in  $clog2(ROWS)  write row
Wr_col  in  $clog2(COLS)  write column
Wr_tile  in  TILE_W  code to write

Behaviour:
- Clock and reset: one clock, Clk. Reset_h is asynchronous and active-high.
- State on reset: FSM in IDLE; Busy=0, Gen_Done=0, tilenumber=0; row, col and lfsr = 0; map_valid=0.
- Map storage: not reset. While map_valid=0, reads return 0.
- FSM states: IDLE, FILL, DONE.
- IDLE/DONE, Gen=1: go to FILL next edge. row=0, col=0, lfsr=Seed, or 16'hACE1 if Seed==0. Gen_Done drops and map_valid clears on the same edge.
- FILL, every cycle:
  - Write map[row][col] = class(lfsr).
  - Advance lfsr: Galois, right shift, XOR with 16'hB400 when the shifted-out bit is 1.
  - col++. When col==COLS-1: col=0, row++.
  - At row==ROWS-1 and col==COLS-1: write the last tile, go to DONE, set Gen_Done=1 and map_valid=1.
  - Fill takes exactly ROWS*COLS cycles. Gen_Done rises on the edge that writes the last tile.
- Gen while in FILL: ignored.
- class(v) when v[8:0] <= FEAT_THRESH, with k = v[14:11]:
  - k>=8 -> 1 (tree)
  - k 6-7 -> 2 (grass1)
  - k 4-5 -> 3 (grass2)
  - k==3 -> 4 (grass3)
  - k<3 -> 5 (stone)
- class(v) otherwise: 0 (plain background).
- Read path:
  - tx = DrawX>>TILE_SHIFT, ty = DrawY>>TILE_SHIFT.
  - tilenumber <= map[ty][tx], one cycle latency.
  - Returns 0 if tx>=COLS or ty>=ROWS, or map_valid=0.
  - Reads during FILL return 0, because map_valid=0.
- Write port:
  - When Wr_en=1 and state!=FILL and Wr_row<ROWS and Wr_col<COLS: map[Wr_row][Wr_col] <= Wr_tile.
  - Otherwise the write is dropped.
- Same-cycle write and read of the same tile: read returns the old value; the new value is visible the next cycle.
- Reset asserted mid-FILL: immediate return to IDLE, Busy=0, map_valid=0. The partial map is never exposed.
- Determinism: same Seed and parameters give a bit-identical map.

Test Plan:
- Fill timing (COLS=4, ROWS=2): Reset, then Gen=1 for 1 cycle with Seed=16'h1234 -> Busy=1 for exactly 8 cycles; Gen_Done=1 after the 8th; tilenumber at (0,0) afterwards equals the model class(16'h1234).
- Determinism (default params): Seed=16'h00FF, fill, dump all 4800 tiles via DrawX/DrawY sweep; regenerate with the same Seed -> identical dump.
  - Seed=0 and Seed=16'hACE1 -> identical maps.
  - Tree/stone/grass counts match the reference model.
- Write port: after DONE, Wr_en with row 5, col 7, tile 5 -> a read at DrawX=56, DrawY=40 returns 5 one cycle after the write. The same write issued during FILL is dropped.
- Out of range: DrawX=640, DrawY=0 -> tilenumber=0. Wr_col=80 -> no map change.
- Reset mid-fill: assert Reset_h at fill cycle 100 -> Busy=0, Gen_Done=0, and all reads return 0 until the next complete fill.
- Gen during FILL ignored: Gen pulses at cycles 10 and 50 -> fill still completes at cycle 4800, with a map identical to the uninterrupted-run map.

Source files
------------

// File: rtl/tile_map_gen.sv
// Background tile-map generator: fills a ROWS x COLS map from a seeded Galois LFSR,
// then serves registered tile lookups for the draw path and single-tile runtime writes.
module tile_map_gen #(
    parameter int unsigned COLS        = 80,
    parameter int unsigned ROWS        = 60,
    parameter int unsigned TILE_SHIFT  = 3,
    parameter int unsigned TILE_W      = 3,
    parameter int unsigned FEAT_THRESH = 20
) (
    input  logic                    Clk,
    input  logic                    Reset_h,
    input  logic                    Gen,
    input  logic [15:0]             Seed,
    output logic                    Busy,
    output logic                    Gen_Done,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    output logic [TILE_W-1:0]       tilenumber,
    input  logic                    Wr_en,
    input  logic [$clog2(ROWS)-1:0] Wr_row,
    input  logic [$clog2(COLS)-1:0] Wr_col,
    input  logic [TILE_W-1:0]       Wr_tile
);

    localparam int unsigned RW    = $clog2(ROWS);
    localparam int unsigned CW    = $clog2(COLS);
    localparam int unsigned Depth = ROWS * COLS;
    localparam int unsigned AW    = $clog2(Depth);

    typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

    state_e            state_q, state_d;
    logic [RW-1:0]     row_q, row_d;
    logic [CW-1:0]     col_q, col_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic [TILE_W-1:0] tile_q, tile_d;
    logic [TILE_W-1:0] map_q [Depth];

    logic          last_tile, gen_ok, map_valid, wr_ok, rd_in;
    logic [9:0]    tx, ty;
    logic [AW-1:0] fill_idx, wr_idx, rd_idx;

    function automatic logic [TILE_W-1:0] tile_class(input logic [8:0] low, input logic [3:0] k);
        logic [2:0] c;
        if (32'(low) > FEAT_THRESH) c = 3'd0;
        else if (k >= 4'd8)         c = 3'd1;
        else if (k >= 4'd6)         c = 3'd2;
        else if (k >= 4'd4)         c = 3'd3;
        else if (k == 4'd3)         c = 3'd4;
        else                        c = 3'd5;
        return TILE_W'(c);
    endfunction

    assign last_tile = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1));
    assign gen_ok    = Gen && (state_q != StFill);
    assign fill_idx  = AW'(32'(row_q) * COLS + 32'(col_q));

    assign wr_ok  = Wr_en && (state_q != StFill) && (32'(Wr_row) < ROWS) && (32'(Wr_col) < COLS);
    assign wr_idx = wr_ok ? AW'(32'(Wr_row) * COLS + 32'(Wr_col)) : '0;

    assign tx     = DrawX >> TILE_SHIFT;
    assign ty     = DrawY >> TILE_SHIFT;
    assign rd_in  = (32'(tx) < COLS) && (32'(ty) < ROWS);
    assign rd_idx = rd_in ? AW'(32'(ty) * COLS + 32'(tx)) : '0;

    always_ff @(posedge Clk or posedge Reset_h) begin
        if (Reset_h) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            lfsr_q  <= '0;
            tile_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            lfsr_q  <= lfsr_d;
            tile_q  <= tile_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: if (Gen) state_d = StFill;
            StFill:         if (last_tile) state_d = StDone;
            default:        state_d = StIdle;
        endcase
    end

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        lfsr_d = lfsr_q;
        if (gen_ok) begin
            row_d  = '0;
            col_d  = '0;
            lfsr_d = (Seed == 16'h0000) ? 16'hACE1 : Seed;
        end else if (state_q == StFill) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
            if (col_q == CW'(COLS - 1)) begin
                col_d = '0;
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_comb begin
        Busy      = (state_q == StFill);
        Gen_Done  = (state_q == StDone);
        map_valid = (state_q == StDone);
    end

    // Old contents are returned on a same-cycle write/read of one tile.
    assign tile_d     = (rd_in && map_valid) ? map_q[rd_idx] : '0;
    assign tilenumber = tile_q;

    always_ff @(posedge Clk) begin
        if (state_q == StFill) begin
            map_q[fill_idx] <= tile_class(lfsr_q[8:0], lfsr_q[14:11]);
        end else if (wr_ok) begin
            map_q[wr_idx] <= Wr_tile;
        end
    end

endmodule
